// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: in-order issue queue and functional-unit selection.
// Optional FU_ISSUE_BYPASS_EN: an RS op arriving at an empty queue selects in its handshake cycle.
package fu_issue_pkg;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU_1  = 3'd1,
    FU_ALU_2  = 3'd2,
    FU_ALU_3  = 3'd3,
    FU_MULT_1 = 3'd4,
    FU_MULT_2 = 3'd5,
    FU_BRANCH = 3'd6
  } fu_select_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest_reg;
    fu_select_t  fu_select;
  } issue_fu_packet_t;

  typedef struct packed {
    logic alu_1;
    logic alu_2;
    logic alu_3;
    logic mult_1;
    logic mult_2;
  } fu_rs_packet_t;

  localparam int ISSUE_W = $bits(issue_fu_packet_t);
  localparam int FU_RS_W = $bits(fu_rs_packet_t);

  localparam logic [1:0] CLASS_ALU  = 2'd0;
  localparam logic [1:0] CLASS_MULT = 2'd1;
  localparam logic [1:0] CLASS_BR   = 2'd2;

endpackage

module fu_issue_ctrl
  import fu_issue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MULT_LAT = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rs_valid,
  input  logic [1:0]              rs_class,
  input  logic [ISSUE_W-1:0]      rs_packet,
  output logic                    rs_ready,
  input  logic                    flush,
  input  logic [FU_RS_W-1:0]      fu_rs_in,
  input  logic                    stall_fu_2_dispatch,
  output logic [ISSUE_W-1:0]      fu_issue_out,
  output logic                    issue_valid,
  output logic [$clog2(DEPTH):0]  queue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MULT_LAT + 1);
  // Loaded on the issuing edge so the next issue lands MULT_LAT cycles later.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);

  logic [1:0]       q_class [DEPTH];
  issue_fu_packet_t q_pkt   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [CW-1:0] mult1_cnt;
  logic [CW-1:0] mult2_cnt;
  logic [1:0]    alu_ptr;

  issue_fu_packet_t out_q;
  logic             out_valid;

  fu_rs_packet_t    hold;
  logic             accept;
  logic             bypass;
  logic             cand_valid;
  logic [1:0]       cand_class;
  issue_fu_packet_t cand_pkt;
  issue_fu_packet_t issue_pkt;

  logic [2:0] alu_free;
  logic       mult1_free;
  logic       mult2_free;
  logic [1:0] a0;
  logic [1:0] a1;
  logic [1:0] a2;
  logic [1:0] alu_pick;
  logic       alu_hit;

  fu_select_t sel;
  logic       issue;
  logic       enq;
  logic       deq;

  function automatic logic [1:0] nxt3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign hold     = fu_rs_packet_t'(fu_rs_in);
  assign rs_ready = (count < (PW+1)'(DEPTH));
  assign accept   = rs_valid & rs_ready
                  & (rs_class != 2'd3) & ~flush;

`ifdef FU_ISSUE_BYPASS_EN
  assign bypass = accept & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign cand_valid = bypass | (count != '0);
  assign cand_class = bypass ? rs_class : q_class[head];
  assign cand_pkt   = bypass ? issue_fu_packet_t'(rs_packet)
                             : q_pkt[head];

  assign alu_free   = {~hold.alu_3, ~hold.alu_2, ~hold.alu_1};
  assign mult1_free = (mult1_cnt == '0) & ~hold.mult_1;
  assign mult2_free = (mult2_cnt == '0) & ~hold.mult_2;

  // Round-robin scan starting at the pointer.
  always_comb begin
    a0       = alu_ptr;
    a1       = nxt3(a0);
    a2       = nxt3(a1);
    alu_hit  = 1'b1;
    alu_pick = a0;
    if (alu_free[a0])      alu_pick = a0;
    else if (alu_free[a1]) alu_pick = a1;
    else if (alu_free[a2]) alu_pick = a2;
    else                   alu_hit  = 1'b0;
  end

  always_comb begin
    sel = FU_NONE;
    if (cand_valid & ~stall_fu_2_dispatch & ~flush) begin
      unique case (cand_class)
        CLASS_ALU: begin
          if (alu_hit)
            sel = fu_select_t'({1'b0, alu_pick} + 3'd1);
        end
        CLASS_MULT: begin
          if (mult1_free)      sel = FU_MULT_1;
          else if (mult2_free) sel = FU_MULT_2;
        end
        CLASS_BR: sel = FU_BRANCH;
        default:  sel = FU_NONE;
      endcase
    end
  end

  assign issue = (sel != FU_NONE);
  assign deq   = issue & ~bypass;
  assign enq   = accept & ~(bypass & issue);

  always_comb begin
    issue_pkt           = cand_pkt;
    issue_pkt.fu_select = sel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      mult1_cnt <= '0;
      mult2_cnt <= '0;
      alu_ptr   <= 2'd0;
    end else begin
      out_q     <= issue ? issue_pkt : '0;
      out_valid <= issue;

      if (issue && sel == FU_MULT_1) mult1_cnt <= MULT_LOAD;
      else if (mult1_cnt != '0)      mult1_cnt <= mult1_cnt - CW'(1);

      if (issue && sel == FU_MULT_2) mult2_cnt <= MULT_LOAD;
      else if (mult2_cnt != '0)      mult2_cnt <= mult2_cnt - CW'(1);

      if (issue && cand_class == CLASS_ALU)
        alu_ptr <= nxt3(alu_pick);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      q_class[tail] <= rs_class;
      q_pkt[tail]   <= issue_fu_packet_t'(rs_packet);
    end
  end

  assign fu_issue_out = out_q;
  assign issue_valid  = out_valid;
  assign queue_count  = count;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb_fu_issue_ctrl: directed per-cycle vectors for fu_issue_ctrl.
// Expected issue cycles shift by one when FU_ISSUE_BYPASS_EN is defined.
module tb_fu_issue_ctrl;
  import fu_issue_pkg::*;

`ifdef FU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam int N = 20;

  logic                clock = 1'b0;
  logic                reset;
  logic                rs_valid;
  logic [1:0]          rs_class;
  logic [ISSUE_W-1:0]  rs_packet;
  logic                rs_ready;
  logic                flush;
  logic [FU_RS_W-1:0]  fu_rs_in;
  logic                stall_fu_2_dispatch;
  logic [ISSUE_W-1:0]  fu_issue_out;
  logic                issue_valid;
  logic [2:0]          queue_count;

  fu_issue_ctrl #(
    .DEPTH    (4),
    .MULT_LAT (5)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .rs_valid            (rs_valid),
    .rs_class            (rs_class),
    .rs_packet           (rs_packet),
    .rs_ready            (rs_ready),
    .flush               (flush),
    .fu_rs_in            (fu_rs_in),
    .stall_fu_2_dispatch (stall_fu_2_dispatch),
    .fu_issue_out        (fu_issue_out),
    .issue_valid         (issue_valid),
    .queue_count         (queue_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic          sv   [N];
  logic [1:0]    sc   [N];
  logic [31:0]   spc  [N];
  fu_rs_packet_t sh   [N];
  logic          sst  [N];
  logic          sfl  [N];
  logic          srst [N];
  fu_select_t    esel [N];
  logic [31:0]   epc  [N];
  int            ecnt [N];

  task automatic check(string tag, logic [127:0] obs,
                       logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic issue_fu_packet_t mkpkt(
    logic [31:0] pc, fu_select_t s);
    issue_fu_packet_t p;
    p.pc        = pc;
    p.inst      = ~pc ^ 32'h5a5a_0013;
    p.dest_reg  = pc[6:2];
    p.fu_select = s;
    return p;
  endfunction

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      sv[i]   = 1'b0;
      sc[i]   = CLASS_ALU;
      spc[i]  = '0;
      sh[i]   = '0;
      sst[i]  = 1'b0;
      sfl[i]  = 1'b0;
      srst[i] = 1'b0;
      esel[i] = FU_NONE;
      epc[i]  = '0;
      ecnt[i] = -1;
    end
  endtask

  task automatic op(int c, logic [1:0] cls, logic [31:0] pc);
    sv[c]  = 1'b1;
    sc[c]  = cls;
    spc[c] = pc;
  endtask

  task automatic want(int c, fu_select_t s, logic [31:0] pc);
    esel[c] = s;
    epc[c]  = pc;
  endtask

  task automatic idle();
    reset               = 1'b0;
    rs_valid            = 1'b0;
    rs_class            = CLASS_ALU;
    rs_packet           = '0;
    flush               = 1'b0;
    fu_rs_in            = '0;
    stall_fu_2_dispatch = 1'b0;
  endtask

  task automatic run(string name, int n);
    issue_fu_packet_t ep;
    for (int c = 0; c < n; c++) begin
      reset               = srst[c];
      rs_valid            = sv[c];
      rs_class            = sc[c];
      rs_packet           = mkpkt(spc[c], fu_select_t'(3'd7));
      flush               = sfl[c];
      fu_rs_in            = sh[c];
      stall_fu_2_dispatch = sst[c];
      @(posedge clock);
      #1;
      ep = (esel[c+1] == FU_NONE) ? '0 : mkpkt(epc[c+1], esel[c+1]);
      check($sformatf("%s c%0d valid", name, c+1),
            128'(issue_valid), 128'(esel[c+1] != FU_NONE));
      check($sformatf("%s c%0d pkt", name, c+1),
            128'(fu_issue_out), 128'(ep));
      if (ecnt[c+1] >= 0) begin
        check($sformatf("%s c%0d count", name, c+1),
              128'(queue_count), 128'(ecnt[c+1]));
        check($sformatf("%s c%0d ready", name, c+1),
              128'(rs_ready), 128'(ecnt[c+1] < 4));
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    check("rst valid", 128'(issue_valid), 128'(0));
    check("rst pkt", 128'(fu_issue_out), 128'(0));
    check("rst ready", 128'(rs_ready), 128'(1));
    check("rst count", 128'(queue_count), 128'(0));
    reset = 1'b0;

    // Four ALU ops rotate through ALU_1..ALU_3 and wrap.
    clear();
    for (int i = 0; i < 4; i++) op(i, CLASS_ALU, 32'h100 + 4*i);
    want(LAT+0, FU_ALU_1, 32'h100);
    want(LAT+1, FU_ALU_2, 32'h104);
    want(LAT+2, FU_ALU_3, 32'h108);
    want(LAT+3, FU_ALU_1, 32'h10c);
    ecnt[LAT+5] = 0;
    run("alu_rr", LAT+5);

    // Three MULTs: third waits out MULT_1 occupancy, ALU waits behind it.
    clear();
    op(0, CLASS_MULT, 32'h200);
    op(1, CLASS_MULT, 32'h204);
    op(2, CLASS_MULT, 32'h208);
    op(3, CLASS_ALU,  32'h20c);
    want(LAT+0, FU_MULT_1, 32'h200);
    want(LAT+1, FU_MULT_2, 32'h204);
    want(LAT+5, FU_MULT_1, 32'h208);
    want(LAT+6, FU_ALU_2,  32'h20c);
    run("mult", LAT+8);

    // ALU_1 and ALU_2 held: both ops land on ALU_3.
    clear();
    for (int i = 0; i < N; i++) begin
      sh[i].alu_1 = 1'b1;
      sh[i].alu_2 = 1'b1;
    end
    op(0, CLASS_ALU, 32'h300);
    op(1, CLASS_ALU, 32'h304);
    want(LAT+0, FU_ALU_3, 32'h300);
    want(LAT+1, FU_ALU_3, 32'h304);
    run("alu_hold", LAT+3);

    // Fill under stall, fifth op refused, then drain four in a row.
    clear();
    for (int i = 0; i < 5; i++) begin
      sst[i] = 1'b1;
      op(i, CLASS_ALU, 32'h400 + 4*i);
    end
    ecnt[1] = 1; ecnt[2] = 2; ecnt[3] = 3; ecnt[4] = 4; ecnt[5] = 4;
    ecnt[6] = 3; ecnt[7] = 2; ecnt[8] = 1; ecnt[9] = 0;
    want(6, FU_ALU_1, 32'h400);
    want(7, FU_ALU_2, 32'h404);
    want(8, FU_ALU_3, 32'h408);
    want(9, FU_ALU_1, 32'h40c);
    run("full", 11);

    // Flush with three queued and a new op arriving: all dropped.
    clear();
    for (int i = 0; i < 4; i++) sst[i] = 1'b1;
    op(0, CLASS_ALU, 32'h500);
    op(1, CLASS_ALU, 32'h504);
    op(2, CLASS_ALU, 32'h508);
    op(3, CLASS_ALU, 32'h50c);
    sfl[3] = 1'b1;
    ecnt[1] = 1; ecnt[2] = 2; ecnt[3] = 3;
    for (int i = 4; i <= 7; i++) ecnt[i] = 0;
    run("flush", 8);

    // Flush leaves MULT_1 occupied; MULT_2 held forces the wait.
    clear();
    for (int i = 0; i < N; i++) sh[i].mult_2 = 1'b1;
    op(0, CLASS_MULT, 32'h600);
    sfl[2] = 1'b1;
    op(3, CLASS_MULT, 32'h604);
    ecnt[3] = 0;
    want(LAT+0, FU_MULT_1, 32'h600);
    want(LAT+5, FU_MULT_1, 32'h604);
    run("flush_mult", LAT+7);

    // Illegal class dropped; branch follows.
    clear();
    op(0, 2'd3, 32'h700);
    op(1, CLASS_BR, 32'h708);
    ecnt[1] = 0;
    want(1+LAT, FU_BRANCH, 32'h708);
    run("class3", LAT+3);

    // Reset mid-operation drops queued ops and rewinds the ALU pointer.
    clear();
    sst[0] = 1'b1;
    sst[1] = 1'b1;
    op(0, CLASS_ALU, 32'h800);
    op(1, CLASS_ALU, 32'h804);
    srst[2] = 1'b1;
    op(3, CLASS_ALU, 32'h808);
    ecnt[2] = 2;
    ecnt[3] = 0;
    want(3+LAT, FU_ALU_1, 32'h808);
    run("reset", LAT+5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fu_issue_ctrl.md
# fu_issue_ctrl

Issue-side controller that feeds the functional-unit cluster. It buffers ready instructions from the reservation station in a small in-order queue and selects a free unit for the queue head each cycle: ALU_1..ALU_3, MULT_1/MULT_2 or BRANCH. It honours the cluster's per-unit hold signals, multiplier occupancy and dispatch stall, and drives a registered ISSUE_FU_PACKET with `fu_select` filled in. It is the transmitting end of the issue→FU interface.

## Interface
- DEPTH, 4, issue queue entries; power of two, at least 2.
- MULT_LAT, 5, multiplier occupancy in cycles; matches the 5-stage multiplier done pipe.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rs_valid  in  1  RS presents a ready instruction.
- rs_class  in  2  0=ALU, 1=MULT, 2=BRANCH; 3 is illegal and dropped.
- rs_packet  in  ISSUE_FU_PACKET  instruction payload; its `fu_select` is ignored.
- rs_ready  out  1  queue can accept this cycle.
- flush  in  1  squash all queued and pending-output instructions.
- fu_rs_in  in  FU_RS_PACKET  per-unit hold (alu_1..alu_3, mult_1, mult_2); an asserted unit is not selectable.
- stall_fu_2_dispatch  in  1  cluster completion congestion; no issue this cycle.
- fu_issue_out  out  ISSUE_FU_PACKET  registered issue packet.
- issue_valid  out  1  fu_issue_out carries an instruction.
- queue_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Queue: circular FIFO with head/tail pointers that wrap modulo DEPTH. Each entry holds class plus packet.
- Enqueue when rs_valid & rs_ready & rs_class!=3.
- rs_ready = (queue_count < DEPTH), computed from registered count. A full queue refuses input even if it dequeues in the same cycle.
- Issue only from the head, in order. A blocked head blocks all younger entries.
- Head issues when stall_fu_2_dispatch=0, flush=0, and a unit of its class is free:
  - ALU: round-robin pointer (reset = ALU_1). Scan from the pointer, skipping units with fu_rs_in.alu_x=1. After an issue, the pointer moves to the unit after the one used (ALU_3 wraps to ALU_1).
  - MULT: MULT_1 if free, else MULT_2. A unit is free only when its occupancy counter is 0 and fu_rs_in.mult_x=0.
  - BRANCH: always free.
- On issue, the output register loads the head packet with `fu_select` set to the chosen unit, issue_valid=1, and the head advances.
- With no issue, the output register loads all-zero: `fu_select` encoding 0 means no unit, and issue_valid=0.
- Multiplier occupancy: issuing to MULT_x loads its counter. The counter decrements every cycle to 0 and saturates there.
- flush:
  - Clears queue pointers and count; the output register loads zero.
  - Multiplier counters are NOT cleared, because in-flight ops still occupy the unit.
  - The ALU pointer is unchanged.
- Simultaneous flush and rs_valid: flush wins and the incoming entry is dropped.
- Simultaneous enqueue and dequeue (not full): count is unchanged; both pointers advance.

## Timing
- Reset values: fu_issue_out='0, issue_valid=0, rs_ready=1, queue_count=0, all multiplier counters 0, ALU pointer=ALU_1.
- An RS handshake in cycle N writes the queue at the end of N.
- Without bypass, the earliest issue is visible in cycle N+2 (selected in N+1, registered).
- Multiplier: if issue to MULT_x is visible in cycle T, the next issue to MULT_x is visible no earlier than cycle T+MULT_LAT.
- fu_rs_in and stall_fu_2_dispatch are sampled in the selection cycle. They affect the output one cycle later.
- flush asserted in cycle F: issue_valid=0 and queue_count=0 in cycle F+1.
- Reset asserted mid-operation returns all state to reset values at the next edge. Queued entries are lost.

## Configuration
- FU_ISSUE_BYPASS_EN defined: when the queue is empty, the accepted RS instruction is selected in the same cycle it is handshaken. If a unit is free, it is issued directly (visible N+1) and is not written to the queue. Otherwise it is enqueued normally.
- Undefined: every instruction passes through the queue. Minimum latency is N+2.

## Test plan
- Reset, then ALU ops in cycles 1,2,3,4 with no holds -> issues in cycles 3..6 with fu_select ALU_1, ALU_2, ALU_3, ALU_1 (N+1 with bypass).
- MULT ops back-to-back ×3 with MULT_LAT=5 -> MULT_1 at T, MULT_2 at T+1, third op stalls the head and issues MULT_1 at T+5. A trailing ALU op waits behind it.
- fu_rs_in.alu_1=1 and alu_2=1 held, 2 ALU ops -> both issue on ALU_3 in consecutive cycles.
- Fill queue to DEPTH=4 with stall_fu_2_dispatch=1 -> rs_ready=0, queue_count=4, issue_valid=0. Release stall -> 4 issues in 4 cycles and rs_ready returns to 1 the cycle after the first dequeue.
- Queue at 3 entries, flush with rs_valid=1 in the same cycle -> next cycle queue_count=0, issue_valid=0, entry dropped. A MULT issued 2 cycles before the flush still blocks MULT_1 until its MULT_LAT window expires.
- rs_class=3 with rs_valid=1 -> not enqueued, queue_count unchanged, no issue.
